iop_writeback: RTL

- Downstream neighbour of the CPU integer-ops stage in sha256crypt.
- Captures that stage's combinational flags (CF/OF/ZF) in the issue cycle, and its registered results one cycle later.
- Selects the result, registers the write toward the register file, and holds the CPU flags register.
- Absorbs register-file port contention with a 1-entry skid buffer, and provides operand forwarding to the fetch stage.

---
 rtl/iop_writeback.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/iop_writeback.sv
// iop_writeback: write-back stage behind the integer-ops unit.
// Captures the issue-cycle flags and, one cycle later, the op result. It then
// drives the register-file write port through a 1-entry skid buffer and holds
// the architectural CF/OF/ZF flags.
// Optional feature macro: IOP_WB_FORWARDING_EN. When it is defined, the
// operand forwarding network toward fetch is built. When it is undefined,
// fwd_hit and fwd_data are tied to 0.
module iop_writeback #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              en,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic              in_wr,
    input  logic [2:0]        in_flag_mask,
    input  logic              flag_cf_in,
    input  logic              flag_of_in,
    input  logic              flag_zf_in,
    input  logic [1:0]        dout_select,
    input  logic [WIDTH-1:0]  dout1,
    input  logic [WIDTH-1:0]  dout2,
    input  logic [WIDTH-1:0]  dout3,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic              stall,
    output logic              flag_cf,
    output logic              flag_of,
    output logic              flag_zf,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [WIDTH-1:0]  fwd_data,
    output logic              err_overrun
);

    typedef enum logic [1:0] {IDLE, WRITE, WRITE_SKID} state_t;

    state_t              state, state_next;
    logic                s1_valid;
    logic [ADDR_W-1:0]   s1_dst;
    logic [WIDTH-1:0]    s1_data;
    logic                s1_live;
    logic                skid_valid, skid_valid_next;
    logic [ADDR_W-1:0]   skid_addr, skid_addr_next;
    logic [WIDTH-1:0]    skid_data, skid_data_next;
    logic                wr_en_next;
    logic [ADDR_W-1:0]   wr_addr_next;
    logic [WIDTH-1:0]    wr_data_next;
    logic                accept;

    // The skid buffer can absorb exactly one entry, so issue is blocked when
    // the port is busy this cycle or the skid is already occupied.
    assign stall  = ((state == WRITE) && !wr_ready) || (state == WRITE_SKID);
    assign accept = en && !stall;

    // Flags, overrun sticky bit and stage-1 tag capture at the issue edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flag_cf     <= 1'b0;
            flag_of     <= 1'b0;
            flag_zf     <= 1'b0;
            err_overrun <= 1'b0;
            s1_valid    <= 1'b0;
            s1_dst      <= '0;
        end else begin
            if (en && stall)
                err_overrun <= 1'b1;
            s1_valid <= accept && in_wr;
            if (accept) begin
                s1_dst <= in_dst;
                if (in_flag_mask[2]) flag_cf <= flag_cf_in;
                if (in_flag_mask[1]) flag_of <= flag_of_in;
                if (in_flag_mask[0]) flag_zf <= flag_zf_in;
            end
        end
    end

    // Select the registered integer-ops result for the stage-1 entry.
    always_comb begin
        s1_data = '0;
        case (dout_select)
            2'd1:    s1_data = dout1;
            2'd2:    s1_data = dout2;
            2'd3:    s1_data = dout3;
            default: s1_data = '0;
        endcase
    end

    // A no-result op (select 0) cancels the stage-1 write.
    assign s1_live = s1_valid && (dout_select != 2'd0);

    // Write-port FSM state, write register and skid buffer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            skid_valid <= 1'b0;
            skid_addr  <= '0;
            skid_data  <= '0;
        end else begin
            state      <= state_next;
            wr_en      <= wr_en_next;
            wr_addr    <= wr_addr_next;
            wr_data    <= wr_data_next;
            skid_valid <= skid_valid_next;
            skid_addr  <= skid_addr_next;
            skid_data  <= skid_data_next;
        end
    end

    // Next-state logic. A write completes on an edge where wr_en and wr_ready
    // are both high. A stage-1 entry that arrives while the port is blocked
    // is parked in the skid buffer.
    always_comb begin
        state_next      = state;
        wr_en_next      = wr_en;
        wr_addr_next    = wr_addr;
        wr_data_next    = wr_data;
        skid_valid_next = skid_valid;
        skid_addr_next  = skid_addr;
        skid_data_next  = skid_data;
        case (state)
            IDLE: begin
                if (s1_live) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = s1_dst;
                    wr_data_next = s1_data;
                    state_next   = WRITE;
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    if (s1_live) begin
                        wr_addr_next = s1_dst;
                        wr_data_next = s1_data;
                    end else begin
                        wr_en_next = 1'b0;
                        state_next = IDLE;
                    end
                end else if (s1_live) begin
                    skid_valid_next = 1'b1;
                    skid_addr_next  = s1_dst;
                    skid_data_next  = s1_data;
                    state_next      = WRITE_SKID;
                end
            end
            WRITE_SKID: begin
                if (wr_ready) begin
                    wr_addr_next    = skid_addr;
                    wr_data_next    = skid_data;
                    skid_valid_next = 1'b0;
                    state_next      = WRITE;
                end
            end
            default: begin
                wr_en_next      = 1'b0;
                skid_valid_next = 1'b0;
                state_next      = IDLE;
            end
        endcase
    end

`ifdef IOP_WB_FORWARDING_EN
    // Forwarding checks the youngest source first: stage 1, then skid, then
    // the pending write.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (s1_live && (s1_dst == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = s1_data;
        end else if (skid_valid && (skid_addr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = skid_data;
        end else if (wr_en && (wr_addr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data;
        end
    end
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^fwd_addr;
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

endmodule
